// File: rtl/pio_shift_out.sv
// pio_shift_out: PIO output shift register, fed by the TX FIFO and stepped by divider ticks.
// Optional stall counter (stall_cnt / stall_clr) is built when PIO_SHIFT_STALL_CNT_EN is defined.
module pio_shift_out #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned PIN_W  = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       tick,
   input  logic                       enable,
   input  logic [$clog2(PIN_W):0]     shift_count,
   input  logic                       shift_right,
   input  logic [$clog2(WORD_W):0]    pull_thresh,
   input  logic [WORD_W-1:0]          tx_data,
   input  logic                       tx_valid,
`ifdef PIO_SHIFT_STALL_CNT_EN
   input  logic                       stall_clr,
   output logic [15:0]                stall_cnt,
`endif
   output logic                       tx_ready,
   output logic [PIN_W-1:0]           pins_out,
   output logic                       pins_valid,
   output logic                       stall
);

   localparam int unsigned SCW = $clog2(PIN_W) + 1;
   localparam int unsigned TW  = $clog2(WORD_W) + 1;
   localparam int unsigned UW  = TW + 1;
   localparam logic [SCW-1:0] N_MAX = SCW'(PIN_W);
   localparam logic [TW-1:0]  T_MAX = TW'(WORD_W);
   localparam logic [UW-1:0]  U_MAX = UW'(WORD_W);

   typedef enum logic {S_EMPTY, S_SHIFT} state_t;

   state_t              r_state, w_state_nx;
   logic [WORD_W-1:0]   r_osr, w_osr_nx;
   logic [UW-1:0]       r_used, w_used_nx;
   logic [PIN_W-1:0]    r_pins, w_pins_nx;
   logic                r_pv, w_pv_nx;
   logic                r_stall, w_stall_nx;
   logic                r_tx_ready, w_tx_ready_nx;

   logic [SCW-1:0]      w_n;
   logic [TW-1:0]       w_t;
   logic [UW-1:0]       w_sum;
   logic [PIN_W-1:0]    w_pins;
   logic                w_load;
   logic                w_tick;

   always_comb begin
      w_n    = (shift_count == '0 || shift_count > N_MAX) ? N_MAX : shift_count;
      w_t    = (pull_thresh == '0 || pull_thresh > T_MAX) ? T_MAX : pull_thresh;
      w_sum  = r_used + UW'(w_n);
      w_load = tx_valid & r_tx_ready;
      w_tick = tick & enable;

      // Left shifts emit MSB-first, so the word's MSB lands on pin 0.
      w_pins = '0;
      for (int unsigned i = 0; i < PIN_W; i++) begin
         if (i < 32'(w_n))
            w_pins[i] = shift_right ? r_osr[i] : r_osr[WORD_W-1-i];
      end

      w_state_nx = r_state;
      w_osr_nx   = r_osr;
      w_used_nx  = r_used;
      w_pins_nx  = r_pins;
      w_pv_nx    = 1'b0;
      w_stall_nx = 1'b0;

      case (r_state)
         S_EMPTY: begin
            if (w_tick)
               w_stall_nx = 1'b1;
            if (w_load) begin
               w_osr_nx   = tx_data;
               w_used_nx  = '0;
               w_state_nx = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_tick) begin
               w_pins_nx = w_pins;
               w_pv_nx   = 1'b1;
               w_osr_nx  = shift_right ? (r_osr >> w_n) : (r_osr << w_n);
               w_used_nx = (w_sum > U_MAX) ? U_MAX : w_sum;
               if (w_sum >= UW'(w_t)) begin
                  w_osr_nx   = '0;
                  w_state_nx = S_EMPTY;
               end
            end
         end
         default: w_state_nx = S_EMPTY;
      endcase

      w_tx_ready_nx = (w_state_nx == S_EMPTY);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= S_EMPTY;
         r_osr      <= '0;
         r_used     <= '0;
         r_pins     <= '0;
         r_pv       <= 1'b0;
         r_stall    <= 1'b0;
         r_tx_ready <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_osr      <= w_osr_nx;
         r_used     <= w_used_nx;
         r_pins     <= w_pins_nx;
         r_pv       <= w_pv_nx;
         r_stall    <= w_stall_nx;
         r_tx_ready <= w_tx_ready_nx;
      end
   end

`ifdef PIO_SHIFT_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_stall_cnt <= '0;
      else if (stall_clr)
         r_stall_cnt <= '0;
      else if (w_stall_nx && r_stall_cnt != '1)
         r_stall_cnt <= r_stall_cnt + 16'd1;
   end

   assign stall_cnt = r_stall_cnt;
`endif

   assign tx_ready   = r_tx_ready;
   assign pins_out   = r_pins;
   assign pins_valid = r_pv;
   assign stall      = r_stall;

endmodule

// File: tb/tb_pio_shift_out.sv
// Directed bench for pio_shift_out; define PIO_SHIFT_STALL_CNT_EN to also cover the stall counter.
module tb_pio_shift_out;

   logic        clock = 1'b0;
   logic        reset;
   logic        tick;
   logic        enable;
   logic [2:0]  shift_count;
   logic        shift_right;
   logic [5:0]  pull_thresh;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [3:0]  pins_out;
   logic        pins_valid;
   logic        stall;
`ifdef PIO_SHIFT_STALL_CNT_EN
   logic        stall_clr;
   logic [15:0] stall_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   pio_shift_out #(.WORD_W(32), .PIN_W(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .tick        (tick),
      .enable      (enable),
      .shift_count (shift_count),
      .shift_right (shift_right),
      .pull_thresh (pull_thresh),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
`ifdef PIO_SHIFT_STALL_CNT_EN
      .stall_clr   (stall_clr),
      .stall_cnt   (stall_cnt),
`endif
      .tx_ready    (tx_ready),
      .pins_out    (pins_out),
      .pins_valid  (pins_valid),
      .stall       (stall)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic load(input logic [31:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      tx_data  = 32'hDEAD_BEEF;
      check_eq("load_ready_low", 32'(tx_ready), 32'd0);
   endtask

   logic [3:0] exp_nib [8] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'h5, 4'hA, 4'h5, 4'hA};

   initial begin
      reset = 1'b0; tick = 1'b0; enable = 1'b1;
      shift_count = 3'd4; shift_right = 1'b1; pull_thresh = 6'd32;
      tx_data = '0; tx_valid = 1'b0;
`ifdef PIO_SHIFT_STALL_CNT_EN
      stall_clr = 1'b0;
`endif
      step(); step();
      check_eq("rst_ready", 32'(tx_ready), 32'd0);
      check_eq("rst_pins", 32'(pins_out), 32'd0);
      check_eq("rst_pv", 32'(pins_valid), 32'd0);
      check_eq("rst_stall", 32'(stall), 32'd0);
      reset = 1'b1;
      check_eq("rel_ready_before_edge", 32'(tx_ready), 32'd0);
      step();
      check_eq("rel_ready_after_edge", 32'(tx_ready), 32'd1);

      // 1: nibbles LSB-first, pull at 32 bits
      load(32'hA5A5_0F0F);
      for (int i = 0; i < 8; i++) begin
         do_tick();
         check_eq($sformatf("t1_pins%0d", i), 32'(pins_out), 32'(exp_nib[i]));
         check_eq($sformatf("t1_pv%0d", i), 32'(pins_valid), 32'd1);
         check_eq($sformatf("t1_ready%0d", i), 32'(tx_ready), (i == 7) ? 32'd1 : 32'd0);
      end
      step();
      check_eq("t1_pv_pulse", 32'(pins_valid), 32'd0);

      // 2: MSB-first single bits, then a mid-word config change empties it
      shift_right = 1'b0; shift_count = 3'd1;
      load(32'h8000_0001);
      do_tick();
      check_eq("t2_bit0", 32'(pins_out), 32'd1);
      do_tick();
      check_eq("t2_bit1", 32'(pins_out), 32'd0);
      check_eq("t2_not_empty", 32'(tx_ready), 32'd0);
      shift_count = 3'd0; pull_thresh = 6'd1;
      do_tick();
      check_eq("t2_cnt0_pins", 32'(pins_out), 32'd0);
      check_eq("t2_empty", 32'(tx_ready), 32'd1);

      // 3: threshold 10 with 4-bit steps -> pull after 3 ticks
      shift_right = 1'b1; shift_count = 3'd4; pull_thresh = 6'd10;
      load(32'hFFFF_FFFF);
      for (int i = 0; i < 3; i++) begin
         do_tick();
         check_eq($sformatf("t3_pins%0d", i), 32'(pins_out), 32'hF);
         check_eq($sformatf("t3_ready%0d", i), 32'(tx_ready), (i == 2) ? 32'd1 : 32'd0);
      end

      // 4: tick while empty -> stall; tick coinciding with a load
      do_tick();
      check_eq("t4_stall", 32'(stall), 32'd1);
      check_eq("t4_no_pv", 32'(pins_valid), 32'd0);
      check_eq("t4_pins_hold", 32'(pins_out), 32'hF);
      step();
      check_eq("t4_stall_pulse", 32'(stall), 32'd0);
      tx_data = 32'h1234_5678; tx_valid = 1'b1; tick = 1'b1;
      step();
      tick = 1'b0; tx_valid = 1'b0;
      check_eq("t4_coinc_stall", 32'(stall), 32'd1);
      check_eq("t4_coinc_pv", 32'(pins_valid), 32'd0);
      check_eq("t4_coinc_loaded", 32'(tx_ready), 32'd0);
      pull_thresh = 6'd32;
      do_tick();
      check_eq("t4_first_nib", 32'(pins_out), 32'h8);
      pull_thresh = 6'd1;
      do_tick();
      check_eq("t4_second_nib", 32'(pins_out), 32'h7);
      check_eq("t4_empty", 32'(tx_ready), 32'd1);

      // shift_count above PIN_W and thresh 0 both mean "full"
      shift_count = 3'd7; pull_thresh = 6'd0;
      load(32'h0000_00F3);
      do_tick();
      check_eq("big_cnt_pins0", 32'(pins_out), 32'h3);
      do_tick();
      check_eq("big_cnt_pins1", 32'(pins_out), 32'hF);
      check_eq("thresh0_not_empty", 32'(tx_ready), 32'd0);
      pull_thresh = 6'd1;
      do_tick();
      check_eq("big_cnt_empty", 32'(tx_ready), 32'd1);

      // 5: enable=0 ignores ticks, load still proceeds
      enable = 1'b0; shift_count = 3'd4; pull_thresh = 6'd32;
      load(32'hCAFE_BABE);
      for (int i = 0; i < 5; i++) begin
         do_tick();
         check_eq($sformatf("t5_no_pv%0d", i), 32'(pins_valid), 32'd0);
         check_eq($sformatf("t5_no_stall%0d", i), 32'(stall), 32'd0);
      end
      enable = 1'b1;
      do_tick();
      check_eq("t5_first_nib", 32'(pins_out), 32'hE);
      check_eq("t5_pv", 32'(pins_valid), 32'd1);

      // 6: asynchronous reset mid-word after 3 ticks
      do_tick();
      check_eq("t6_nib1", 32'(pins_out), 32'hB);
      do_tick();
      check_eq("t6_nib2", 32'(pins_out), 32'hA);
      #3;
      reset = 1'b0;
      #1;
      check_eq("t6_async_pins", 32'(pins_out), 32'd0);
      check_eq("t6_async_ready", 32'(tx_ready), 32'd0);
      step();
      reset = 1'b1;
      check_eq("t6_rel_ready_before", 32'(tx_ready), 32'd0);
      step();
      check_eq("t6_rel_ready_after", 32'(tx_ready), 32'd1);
      do_tick();
      check_eq("t6_word_lost_stall", 32'(stall), 32'd1);

`ifdef PIO_SHIFT_STALL_CNT_EN
      step();
      stall_clr = 1'b1;
      step();
      stall_clr = 1'b0;
      check_eq("cnt_cleared0", 32'(stall_cnt), 32'd0);
      for (int i = 0; i < 3; i++) do_tick();
      check_eq("cnt_three", 32'(stall_cnt), 32'd3);
      tick = 1'b1; stall_clr = 1'b1;
      step();
      tick = 1'b0; stall_clr = 1'b0;
      check_eq("cnt_clear_wins", 32'(stall_cnt), 32'd0);
`endif

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
